// File: rtl/mux_n_scan.sv
// Registered N:1 channel multiplexer with manual select and round-robin scan.
// dout and cur_ch are always updated together, so the tag matches the data.
module mux_n_scan #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int DWELL = 3,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  hold,
  output logic [WIDTH-1:0]      dout,
  output logic [SEL_W-1:0]      cur_ch,
  output logic                  dout_vld,
  output logic                  wrap
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [SEL_W:0]   N_CH_X  = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);

  logic [WIDTH-1:0] ch_data [N_CH];
  logic [SEL_W-1:0] ch_reg, ch_next;
  logic [DW_W-1:0]  dwell_reg, dwell_next;
  logic             wrap_next;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    ch_next    = ch_reg;
    dwell_next = '0;
    wrap_next  = 1'b0;
    if (!mode) begin
      // Out-of-range selects keep the previously shown channel.
      if ({1'b0, sel} < N_CH_X) ch_next = sel;
    end else if (hold) begin
      dwell_next = dwell_reg;
    end else if (dwell_reg == DW_LAST) begin
      ch_next   = (ch_reg == LAST_CH) ? '0 : ch_reg + 1'b1;
      wrap_next = (ch_reg == LAST_CH);
    end else begin
      dwell_next = dwell_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_reg    <= '0;
      dwell_reg <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      ch_reg    <= ch_next;
      dwell_reg <= dwell_next;
      dout      <= ch_data[ch_next];
      dout_vld  <= 1'b1;
      wrap      <= wrap_next;
    end
  end

  assign cur_ch = ch_reg;

endmodule
